// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus wait-state generator: cycle classes,
// wait-count type, FSM state encoding and the cycle classifier.
package z80_bus_pkg;

    typedef enum logic [2:0] {
        MEM   = 3'd0,
        FETCH = 3'd1,
        SLOW  = 3'd2,
        IO    = 3'd3,
        INTA  = 3'd4
    } cyc_type_e;

    typedef logic [2:0] wait_cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } wait_state_e;

    // Highest priority first: INTA, IO, FETCH, SLOW, MEM.
    function automatic cyc_type_e classify(input logic       m1_n,
                                           input logic       iorq_n,
                                           input logic [3:0] page,
                                           input logic [3:0] slow_page);
        cyc_type_e c;
        if (!m1_n && !iorq_n) begin
            c = INTA;
        end else if (!iorq_n) begin
            c = IO;
        end else if (!m1_n) begin
            c = FETCH;
        end else if (page == slow_page) begin
            c = SLOW;
        end else begin
            c = MEM;
        end
        return c;
    endfunction

endpackage

// File: rtl/z80_wait_gen_if.sv
// Bus bundle between the CPU bus wrapper (master) and the wait-state
// generator (slave).
interface z80_wait_gen_if;
    import z80_bus_pkg::*;

    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rfsh_n;
    logic [15:0] A;
    logic        ext_wait_n;
    logic        wait_n;
    cyc_type_e   cyc_type;
    logic        busy;

    modport master (
        output m1_n, mreq_n, iorq_n, rfsh_n, A, ext_wait_n,
        input  wait_n, cyc_type, busy
    );

    modport slave (
        input  m1_n, mreq_n, iorq_n, rfsh_n, A, ext_wait_n,
        output wait_n, cyc_type, busy
    );
endinterface

// File: rtl/z80_wait_sync.sv
// Two-flop synchronizer resetting to 1 (wait released) for an
// asynchronous external wait request.
module z80_wait_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/z80_wait_gen.sv
// Z80 bus wait-state generator: classifies each bus cycle at its start
// and holds wait_n low for a per-class number of clocks, merged with an
// external device wait.
// Optional macro Z80_WAIT_EXT_SYNC_EN: route ext_wait_n through a
// 2-flop synchronizer (2 clocks latency) instead of using it directly.
module z80_wait_gen
    import z80_bus_pkg::*;
#(
    parameter int unsigned M1_WAIT   = 1,
    parameter int unsigned MEM_WAIT  = 0,
    parameter int unsigned SLOW_WAIT = 2,
    parameter logic [3:0]  SLOW_PAGE = 4'hF,
    parameter int unsigned IO_WAIT   = 1,
    parameter int unsigned INTA_WAIT = 2
) (
    input logic           clk,
    input logic           reset,
    z80_wait_gen_if.slave bus
);

    wait_state_e state_q;
    logic        wait_q;
    wait_cnt_t   cnt_q;
    logic        strb_q;
    cyc_type_e   cyc_type_q;

    logic        strb_s;
    logic        start_s;
    cyc_type_e   class_s;
    wait_cnt_t   n_s;
    logic        ext_w_s;
    logic        unused_a_s;

    // Only the page bits of the address take part in classification.
    assign unused_a_s = ^bus.A[11:0];

    // Strobe decode, cycle start edge, class and its wait count.
    always_comb begin
        // Refresh masks MREQ, which also hides the M1 T3 MREQ gap.
        strb_s  = (~bus.mreq_n & bus.rfsh_n) | ~bus.iorq_n;
        start_s = strb_s & ~strb_q;
        class_s = classify(bus.m1_n, bus.iorq_n, bus.A[15:12], SLOW_PAGE);
        case (class_s)
            FETCH:   n_s = wait_cnt_t'(M1_WAIT);
            SLOW:    n_s = wait_cnt_t'(SLOW_WAIT);
            IO:      n_s = wait_cnt_t'(IO_WAIT);
            INTA:    n_s = wait_cnt_t'(INTA_WAIT);
            MEM:     n_s = wait_cnt_t'(MEM_WAIT);
            default: n_s = wait_cnt_t'(MEM_WAIT);
        endcase
    end

    // Wait FSM: start in IDLE loads the count, COUNT holds wait low for
    // N clocks, HOLD blocks re-trigger until the strobe drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= 1'b1;
            cnt_q      <= 3'd0;
            strb_q     <= 1'b0;
            cyc_type_q <= MEM;
        end else begin
            strb_q <= strb_s;
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        cyc_type_q <= class_s;
                        if (n_s != 3'd0) begin
                            cnt_q   <= n_s - 3'd1;
                            wait_q  <= 1'b0;
                            state_q <= COUNT;
                        end else begin
                            wait_q  <= 1'b1;
                            state_q <= HOLD;
                        end
                    end
                end
                COUNT: begin
                    // A dropped strobe aborts the cycle before counting.
                    if (!strb_s) begin
                        wait_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (cnt_q == 3'd0) begin
                        wait_q  <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                HOLD: begin
                    if (!strb_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    wait_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef Z80_WAIT_EXT_SYNC_EN
    z80_wait_sync u_ext_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.ext_wait_n),
        .q_o   (ext_w_s)
    );
`else
    // Synchronous device wait goes straight through with no latency.
    assign ext_w_s = bus.ext_wait_n;
`endif

    assign bus.wait_n   = wait_q & ext_w_s;
    assign bus.busy     = ~wait_q;
    assign bus.cyc_type = cyc_type_q;

endmodule
